pci_target_responder: RTL and testbench
=======================================

// Module: pci_target_responder
// PURPOSE
//  PCI target (slave) answering the master's memory transactions on the shared 32-bit bus.
//  Decodes memory read (4'b0110) and memory write (4'b0111) to a DEPTH-word window at BASE_ADDR.
//  Serves linear bursts from internal storage. Runs on clk, the free-running system clock.
//  AD is split into ad_in/ad_out/ad_oe; the top level builds the tri-state.
// PARAMETERS
//  BASE_ADDR  32'h0000_1000  byte address of word 0; aligned to DEPTH*4
//  DEPTH      16             words in the window; power of two, >= 2
// PORTS
//  clk       in   1   bus clock; all logic on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  frame_n   in   1   FRAME#, from master
//  irdy_n    in   1   IRDY#, from master
//  c_be_n    in   4   command in address phase, byte enables (active low) in data phases
//  ad_in     in   32  AD sampled from bus
//  ad_out    out  32  AD driven by target (reads)
//  ad_oe     out  1   1 = target drives AD
//  devsel_n  out  1   DEVSEL#
//  trdy_n    out  1   TRDY#
//  stop_n    out  1   STOP#
// BEHAVIOUR
//  Reset (async assert, sync release): devsel_n=trdy_n=stop_n=1, ad_oe=0, ad_out=0, state IDLE.
//  Storage is not cleared by reset. Reset mid-transaction drops all outputs the same way.
//  Address phase: in IDLE, frame_n sampled low -> latch ad_in[31:2] and c_be_n as cmd.
//  Hit: BASE_ADDR <= addr < BASE_ADDR+DEPTH*4 and cmd is read/write. ad_in[1:0] ignored.
//  Miss or other cmd: no response; wait for frame_n=1 and irdy_n=1, then IDLE (master abort).
//  Transfer: a data phase completes on an edge with irdy_n=0 and trdy_n=0.
//  States:
//   IDLE  -> WR on write hit, -> RTA on read hit
//   WR    devsel_n=0 and trdy_n=0 from cycle after address phase (fast decode, 0 wait)
//         on transfer: write word, honour c_be_n per byte; index+1
//   RTA   read turnaround: devsel_n=0, ad_oe=1, trdy_n=1; ad_out=mem[index]; -> RD
//   RD    trdy_n=0, ad_out=mem[index]; on transfer: index+1, present next word same cycle
//   TURN  last phase done: devsel_n=trdy_n=stop_n=1, ad_oe=0 for 1 cycle; -> IDLE
//  Last phase: transfer while frame_n=1 -> TURN.
//  Window end (disconnect with data): in the phase addressing word DEPTH-1 while frame_n=0,
//   stop_n=0 alongside trdy_n=0. After that transfer: trdy_n=1, hold stop_n=0 and devsel_n=0
//   until frame_n=1, then TURN. The index never wraps.
//  Master wait states: irdy_n=1 holds all target outputs and index unchanged.
//  Latency: write data accepted 1 cycle after address phase; read data valid 2 cycles after.
//  Back-to-back: a new address phase is only recognised from IDLE. The TURN cycle is mandatory.
// STRUCTURE
//  pkg pci_defs: CMD_MEM_READ=4'b0110, CMD_MEM_WRITE=4'b0111, state enum
//   {IDLE,WR,RTA,RD,DISC,TURN}, bus widths. Reused by the master side.
//  Sub-module pci_target_mem: DEPTH x 32 array, byte-enabled sync write, async read.
//  Top: FSM, address latch/index counter, hit decode, output registers.
// TESTING
//  1 Single write 0xDEADBEEF to 0x1004, c_be_n=0 -> devsel_n/trdy_n low 1 cycle later; mem[1]=DEADBEEF; TURN then IDLE.
//  2 Single read 0x1004 -> ad_oe=1 in RTA; trdy_n low next cycle with ad_out=DEADBEEF.
//  3 Write to 0x1008 with c_be_n=4'b1010 over 0x11223344, old 0 -> mem[2]=0x00220044.
//  4 Write burst of 4 from 0x1000 with irdy_n high 2 cycles mid-burst -> mem[0..3] correct; no extra writes.
//  5 Read burst from 0x1038, master wants 4 -> 2 words; stop_n low with word 15; stop_n held until frame_n=1.
//  6 Access 0x2000 or cmd 4'b0010 -> devsel_n stays 1 throughout. Async rst_n low mid-read burst -> all outputs idle at once.

Source files
------------

// File: rtl/pci_target_responder_pkg.sv
// Shared PCI definitions: bus widths, memory command codes and the target FSM states.
// Reused by both the target and master sides of the bus.
package pci_defs;

  localparam int BUS_W = 32;
  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RTA,
    RD,
    DISC,
    TURN
  } state_e;

endpackage

// File: rtl/pci_target_responder_mem.sv
// Target storage: DEPTH x 32-bit words, byte-enabled synchronous write, asynchronous read.
// One shared index serves both ports because a data phase is either a read or a write.
module pci_target_mem
  import pci_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [BUS_W-1:0] wdata_i,
  output logic [BUS_W-1:0] rdata_o
);

  logic [BUS_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; clearing it would cost a mux per bit and the
  // contents must survive a bus reset anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pci_target_responder.sv
// PCI memory target: decodes a DEPTH-word window at BASE_ADDR and serves linear
// read/write bursts, disconnecting with data at the last word of the window.
module pci_target_responder
  import pci_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_n,
  input  logic             irdy_n,
  input  logic [CMD_W-1:0] c_be_n,
  input  logic [BUS_W-1:0] ad_in,
  output logic [BUS_W-1:0] ad_out,
  output logic             ad_oe,
  output logic             devsel_n,
  output logic             trdy_n,
  output logic             stop_n
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic             abort_q, devsel_q, trdy_q, stop_q, oe_q;
  logic             hit, xfer, last_word, data_state, mem_we;
  logic [BUS_W-1:0] rdata;
  logic             unused_ad;

  // Assert asynchronously, release two edges later so no flop sees a runt release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign hit        = ad_in[31:AW+2] == BASE_ADDR[31:AW+2];
  assign xfer       = !irdy_n && !trdy_q;
  assign last_word  = idx_q == AW'(DEPTH - 1);
  assign data_state = (state_q == WR) || (state_q == RD);
  assign mem_we     = (state_q == WR) && xfer;
  assign unused_ad  = ^ad_in[1:0];

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      abort_q  <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (abort_q) begin
            if (frame_n && irdy_n) abort_q <= 1'b0;
          end else if (!frame_n) begin
            idx_q <= ad_in[AW+1:2];
            if (hit && c_be_n == CMD_MEM_WRITE) begin
              state_q  <= WR;
              devsel_q <= 1'b0;
              trdy_q   <= 1'b0;
            end else if (hit && c_be_n == CMD_MEM_READ) begin
              state_q  <= RTA;
              devsel_q <= 1'b0;
              oe_q     <= 1'b1;
            end else begin
              abort_q <= 1'b1;
            end
          end
        end
        WR, RD: begin
          if (xfer) begin
            if (frame_n) begin
              state_q  <= TURN;
              devsel_q <= 1'b1;
              trdy_q   <= 1'b1;
              oe_q     <= 1'b0;
            end else if (last_word) begin
              state_q <= DISC;
              trdy_q  <= 1'b1;
              stop_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        RTA: begin
          state_q <= RD;
          trdy_q  <= 1'b0;
        end
        DISC: begin
          if (frame_n) begin
            state_q  <= TURN;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
            oe_q     <= 1'b0;
          end
        end
        TURN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pci_target_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (~c_be_n),
    .addr_i  (idx_q),
    .wdata_i (ad_in),
    .rdata_o (rdata)
  );

  // STOP# must already be low in the phase that addresses the last word, so it
  // combines the registered hold with the live FRAME# of that phase.
  assign stop_n   = stop_q & ~(data_state & last_word & ~frame_n);
  assign devsel_n = devsel_q;
  assign trdy_n   = trdy_q;
  assign ad_oe    = oe_q;
  assign ad_out   = oe_q ? rdata : '0;

endmodule

// File: tb/tb_pci_target_responder.sv
// Randomized bench for pci_target_responder: a bus-master model drives bursts,
// a word-array reference model predicts read data, a monitor checks every read transfer.
module tb_pci_target_responder;
  import pci_defs::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_n, irdy_n;
  logic [3:0]  c_be_n;
  logic [31:0] ad_in, ad_out;
  logic        ad_oe, devsel_n, trdy_n, stop_n;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] rd_q [$];

  pci_target_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .c_be_n   (c_be_n),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .stop_n   (stop_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_bus();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    c_be_n  = 4'hF;
    ad_in   = '0;
  endtask

  // Monitor: every completed read data phase must carry the next predicted word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && irdy_n === 1'b0 && trdy_n === 1'b0 && ad_oe === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected_q_size", rd_q.size(), 1);
      else                  check("rd_data", ad_out, rd_q.pop_front());
    end
  end

  // Master burst of n phases; the target may cut it short at the window end.
  task automatic bus_xfer(input bit wr, input logic [31:0] addr, input int n, input bit waits,
                          input bit fixed, input logic [31:0] fdata, input logic [3:0] fbe);
    int sw, exp_n, k, cyc, hold;
    bit done, stopped, pend;
    logic [31:0] d;
    logic [3:0]  be;
    sw    = int'((addr - BASE) >> 2);
    exp_n = (n < DEPTH - sw) ? n : DEPTH - sw;
    d = '0;
    be = '0;
    @(posedge clk); #1;
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = addr;
    c_be_n  = wr ? CMD_MEM_WRITE : CMD_MEM_READ;
    @(posedge clk);
    k = 0; cyc = 0; done = 0; stopped = 0; pend = 0;
    while (!done) begin
      #1;
      if (!pend) begin
        if (waits && $urandom_range(0, 2) == 0) begin
          irdy_n = 1'b1; frame_n = 1'b0;
        end else begin
          pend = 1; irdy_n = 1'b0; frame_n = (k == n - 1);
          if (wr) begin
            d  = fixed ? fdata : $urandom;
            be = fixed ? fbe : 4'($urandom_range(0, 15));
            ad_in = d; c_be_n = be;
          end else begin
            ad_in = '0; c_be_n = 4'h0;
            rd_q.push_back(ref_mem[sw + k]);
          end
        end
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("first_devsel", devsel_n, 0);
        check(wr ? "wr_trdy_lat" : "rta_trdy", trdy_n, wr ? 0 : 1);
        if (!wr) check("rta_oe", ad_oe, 1);
      end
      if (cyc == 2 && !wr) check("rd_trdy_lat", trdy_n, 0);
      if (!irdy_n && !trdy_n) begin
        check("stop_at_xfer", stop_n, (sw + k == DEPTH - 1 && k != n - 1) ? 0 : 1);
        if (wr)
          for (int b = 0; b < 4; b++)
            if (!be[b]) ref_mem[sw + k][8*b +: 8] = d[8*b +: 8];
        pend = 0;
        if (k == n - 1) done = 1;
        else if (!stop_n) begin stopped = 1; done = 1; end
        k++;
      end
      if (!done && cyc > 4 * n + 8) begin
        check("xfer_timeout_cyc", cyc, 4 * n + 8);
        done = 1;
      end
      @(posedge clk);
    end
    check("xfer_count", k, exp_n);
    if (stopped) begin
      hold = $urandom_range(0, 2);
      for (int h = 0; h <= hold; h++) begin
        #1; irdy_n = 1'b1; frame_n = (h == hold);
        @(negedge clk);
        check("disc_outs", {devsel_n, trdy_n, stop_n}, 3'b010);
        @(posedge clk);
      end
    end
    #1; idle_bus();
    @(negedge clk);
    check("turn_outs", {devsel_n, trdy_n, stop_n, ad_oe}, 4'b1110);
    @(posedge clk);
  endtask

  // Address outside the window or unsupported command: target must stay silent.
  task automatic bus_miss(input logic [31:0] addr, input logic [3:0] cmd);
    @(posedge clk); #1;
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = addr; c_be_n = cmd;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      frame_n = (c >= 3); irdy_n = (c == 4); ad_in = $urandom; c_be_n = 4'h0;
      @(negedge clk);
      check("miss_outs", {devsel_n, trdy_n, stop_n, ad_oe}, 4'b1110);
    end
    @(posedge clk); #1; idle_bus();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {devsel_n, trdy_n, stop_n, ad_oe}, 4'b1110);
    check("reset_ad_out", ad_out, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    bus_xfer(1, BASE, 16, 0, 0, '0, '0);
    bus_xfer(1, BASE + 32'h4, 1, 0, 1, 32'hDEAD_BEEF, 4'h0);
    bus_xfer(0, BASE + 32'h4, 1, 0, 0, '0, '0);
    bus_xfer(1, BASE + 32'h8, 1, 0, 1, 32'h0, 4'h0);
    bus_xfer(1, BASE + 32'h8, 1, 0, 1, 32'h1122_3344, 4'b1010);
    bus_xfer(0, BASE + 32'h8, 1, 0, 0, '0, '0);
    bus_xfer(1, BASE, 4, 1, 0, '0, '0);
    bus_xfer(0, BASE, 4, 1, 0, '0, '0);
    bus_xfer(0, BASE + 32'h38, 4, 0, 0, '0, '0);
    bus_xfer(1, BASE + 32'h30, 8, 1, 0, '0, '0);
    bus_miss(32'h0000_2000, CMD_MEM_READ);
    bus_miss(BASE + 32'h4, 4'b0010);
    bus_miss(32'h0000_0FFC, CMD_MEM_WRITE);

    for (int t = 0; t < 25; t++) begin
      bus_xfer(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, DEPTH - 1)) * 4,
               $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0, '0, '0);
    end
    bus_xfer(0, BASE, 16, 1, 0, '0, '0);

    // Reset mid read burst: outputs must drop without waiting for a clock edge.
    @(posedge clk); #1;
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = BASE + 32'h8; c_be_n = CMD_MEM_READ;
    @(posedge clk); #1;
    ad_in = '0; c_be_n = 4'h0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_trdy", trdy_n, 0);
    check("pre_rst_oe", ad_oe, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {devsel_n, trdy_n, stop_n, ad_oe}, 4'b1110);
    check("rst_async_ad", ad_out, 0);
    idle_bus();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    bus_xfer(0, BASE, 16, 0, 0, '0, '0);

    check("rd_q_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
